// File: rtl/acpi_pkg.sv
// Shared state enum and output/request encodings for the ACPI sleep controller.
// The S3 state exists only when PMS_ACPI_S3_EN is defined.
package acpi_pkg;

`ifdef PMS_ACPI_S3_EN
    typedef enum logic [2:0] {ST_S5, ST_PWRUP, ST_S0, ST_PWRDN, ST_S3} acpi_state_e;
`else
    typedef enum logic [2:0] {ST_S5, ST_PWRUP, ST_S0, ST_PWRDN} acpi_state_e;
`endif

    localparam logic [1:0] STATE_O_S0    = 2'b00;
    localparam logic [1:0] STATE_O_S3    = 2'b01;
    localparam logic [1:0] STATE_O_TRANS = 2'b10;
    localparam logic [1:0] STATE_O_S5    = 2'b11;

    localparam logic [1:0] REQ_S3 = 2'b01;
    localparam logic [1:0] REQ_S5 = 2'b11;

    typedef struct packed {
        logic       slp_s3;
        logic       slp_s5;
        logic [1:0] code;
        logic       rdy;
    } acpi_outs_t;

    // Registered output values that belong to each FSM state.
    function automatic acpi_outs_t state_outs(input acpi_state_e st);
        acpi_outs_t o;
        o = '{slp_s3: 1'b1, slp_s5: 1'b1, code: STATE_O_S5, rdy: 1'b0};
        case (st)
            ST_PWRUP: o = '{slp_s3: 1'b0, slp_s5: 1'b0, code: STATE_O_TRANS, rdy: 1'b0};
            ST_S0:    o = '{slp_s3: 1'b0, slp_s5: 1'b0, code: STATE_O_S0,    rdy: 1'b1};
            ST_PWRDN: o = '{slp_s3: 1'b1, slp_s5: 1'b1, code: STATE_O_TRANS, rdy: 1'b0};
`ifdef PMS_ACPI_S3_EN
            ST_S3:    o = '{slp_s3: 1'b1, slp_s5: 1'b0, code: STATE_O_S3,    rdy: 1'b0};
`endif
            default:  o = '{slp_s3: 1'b1, slp_s5: 1'b1, code: STATE_O_S5,    rdy: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/acpi_btn_debounce.sv
// Power-button 2-flop synchronizer and debouncer; emits the debounced level
// plus one-cycle press and release pulses when the level changes.
module acpi_btn_debounce #(
    parameter int unsigned DebounceCycles = 1000,
    parameter int unsigned CntWidth       = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CntWidth-1:0] DEB_LAST = CntWidth'(DebounceCycles - 1);

    logic                btn_sync_p0;
    logic                btn_sync_p1;
    logic [CntWidth-1:0] stable_cnt;

    // The level flips only after the synced input has disagreed with it
    // for DebounceCycles consecutive cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_sync_p0 <= 1'b0;
            btn_sync_p1 <= 1'b0;
            stable_cnt  <= '0;
            level_o     <= 1'b0;
            press_o     <= 1'b0;
            release_o   <= 1'b0;
        end else begin
            btn_sync_p0 <= btn_i;
            btn_sync_p1 <= btn_sync_p0;
            press_o     <= 1'b0;
            release_o   <= 1'b0;
            if (btn_sync_p1 == level_o) begin
                stable_cnt <= '0;
            end else if (stable_cnt >= DEB_LAST) begin
                stable_cnt <= '0;
                level_o    <= btn_sync_p1;
                press_o    <= btn_sync_p1;
                release_o  <= ~btn_sync_p1;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pms_acpi_sleep_ctrl.sv
// ACPI sleep-state controller: power button, pwr_good sequencing and software
// sleep requests. Define PMS_ACPI_S3_EN to add S3 (suspend-to-RAM) support.
module pms_acpi_sleep_ctrl
    import acpi_pkg::*;
#(
    parameter int unsigned DebounceCycles  = 1000,
    parameter int unsigned LongPressCycles = 4000000,
    parameter int unsigned PwrGoodTimeout  = 100000,
    parameter int unsigned CntWidth        = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pwr_btn_i,
    input  logic       pwr_good_i,
    input  logic       sw_req_valid_i,
    input  logic [1:0] sw_req_state_i,
    output logic       sw_req_ready_o,
    output logic       slp_s3_o,
    output logic       slp_s5_o,
    output logic [1:0] state_o,
    output logic       btn_irq_o,
    output logic       fault_o
);

    localparam logic [CntWidth-1:0] LONG_LIM  = CntWidth'(LongPressCycles);
    localparam logic [CntWidth-1:0] LONG_LAST = CntWidth'(LongPressCycles - 1);
    localparam logic [CntWidth-1:0] TMO_LAST  = CntWidth'(PwrGoodTimeout - 1);

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                btn_lvl;
    logic                btn_press;
    logic                btn_rel;
    logic                pg_sync_p0;
    logic                pg_sync_p1;
    acpi_state_e         state;
    acpi_outs_t          outs;
    logic                consumed;
    logic [CntWidth-1:0] hold_cnt;
    logic [CntWidth-1:0] tmo_cnt;
    logic                long_hit;

    acpi_btn_debounce #(
        .DebounceCycles(DebounceCycles),
        .CntWidth      (CntWidth)
    ) u_btn (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .btn_i    (pwr_btn_i),
        .level_o  (btn_lvl),
        .press_o  (btn_press),
        .release_o(btn_rel)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pg_sync_p0 <= 1'b0;
            pg_sync_p1 <= 1'b0;
        end else begin
            pg_sync_p0 <= pwr_good_i;
            pg_sync_p1 <= pg_sync_p0;
        end
    end

    assign long_hit       = btn_lvl && (hold_cnt >= LONG_LAST);
    assign sw_req_ready_o = outs.rdy;
    assign slp_s3_o       = outs.slp_s3;
    assign slp_s5_o       = outs.slp_s5;
    assign state_o        = outs.code;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_S5;
            outs      <= state_outs(ST_S5);
            btn_irq_o <= 1'b0;
            fault_o   <= 1'b0;
            consumed  <= 1'b0;
            hold_cnt  <= '0;
            tmo_cnt   <= '0;
        end else begin
            btn_irq_o <= 1'b0;
            tmo_cnt   <= sat_inc(tmo_cnt);
            hold_cnt  <= (state == ST_S0 && btn_lvl) ? sat_inc(hold_cnt) : '0;

            // A press that did not start in S0 can never become a short press.
            if (btn_rel)
                consumed <= 1'b0;
            else if (btn_press && state != ST_S0)
                consumed <= 1'b1;

            case (state)
                ST_S5: begin
                    if (btn_press) begin
                        fault_o <= 1'b0;
                        state   <= ST_PWRUP;
                        outs    <= state_outs(ST_PWRUP);
                        tmo_cnt <= '0;
                    end
                end
                ST_PWRUP: begin
                    if (pg_sync_p1) begin
                        state <= ST_S0;
                        outs  <= state_outs(ST_S0);
                    end else if (tmo_cnt >= TMO_LAST) begin
                        fault_o <= 1'b1;
                        state   <= ST_PWRDN;
                        outs    <= state_outs(ST_PWRDN);
                        tmo_cnt <= '0;
                    end
                end
                ST_S0: begin
                    // Long press outranks a same-cycle software request.
                    if (long_hit) begin
                        consumed <= 1'b1;
                        state    <= ST_PWRDN;
                        outs     <= state_outs(ST_PWRDN);
                        tmo_cnt  <= '0;
                    end else if (sw_req_valid_i && sw_req_state_i == REQ_S5) begin
                        state   <= ST_PWRDN;
                        outs    <= state_outs(ST_PWRDN);
                        tmo_cnt <= '0;
`ifdef PMS_ACPI_S3_EN
                    end else if (sw_req_valid_i && sw_req_state_i == REQ_S3) begin
                        state <= ST_S3;
                        outs  <= state_outs(ST_S3);
`endif
                    end else if (btn_rel && !consumed && hold_cnt < LONG_LIM) begin
                        btn_irq_o <= 1'b1;
                    end
                end
                ST_PWRDN: begin
                    if (!pg_sync_p1 || tmo_cnt >= TMO_LAST) begin
                        if (pg_sync_p1)
                            fault_o <= 1'b1;
                        state <= ST_S5;
                        outs  <= state_outs(ST_S5);
                    end
                end
`ifdef PMS_ACPI_S3_EN
                ST_S3: begin
                    if (btn_press) begin
                        state   <= ST_PWRUP;
                        outs    <= state_outs(ST_PWRUP);
                        tmo_cnt <= '0;
                    end
                end
`endif
                default: begin
                    state <= ST_S5;
                    outs  <= state_outs(ST_S5);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pms_acpi_sleep_ctrl.sv
// Self-checking bench for pms_acpi_sleep_ctrl with short debounce/timeout
// parameters; press outcomes come from a press-length rule model.
module tb_pms_acpi_sleep_ctrl;

    localparam int DEB    = 4;
    localparam int LONG_P = 64;
    localparam int TMO    = 32;

    localparam int OUT_NONE  = 0;
    localparam int OUT_IRQ   = 1;
    localparam int OUT_PWRDN = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwr_btn;
    logic       pwr_good;
    logic       sw_valid;
    logic [1:0] sw_state;
    logic       sw_ready;
    logic       slp_s3;
    logic       slp_s5;
    logic [1:0] state_o;
    logic       btn_irq;
    logic       fault;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int irq_cnt  = 0;
    int last_irq_cyc = 0;
    int exp_irq  = 0;

    pms_acpi_sleep_ctrl #(
        .DebounceCycles (DEB),
        .LongPressCycles(LONG_P),
        .PwrGoodTimeout (TMO),
        .CntWidth       (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pwr_btn_i     (pwr_btn),
        .pwr_good_i    (pwr_good),
        .sw_req_valid_i(sw_valid),
        .sw_req_state_i(sw_state),
        .sw_req_ready_o(sw_ready),
        .slp_s3_o      (slp_s3),
        .slp_s5_o      (slp_s5),
        .state_o       (state_o),
        .btn_irq_o     (btn_irq),
        .fault_o       (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (btn_irq === 1'b1) begin
            irq_cnt      = irq_cnt + 1;
            last_irq_cyc = cyc;
        end
    end

    // Rule model: a stable press shorter than the debounce window is invisible,
    // one reaching the long-press length powers down, anything between is a short press.
    function automatic int press_outcome(input int len);
        if (len < DEB)
            return OUT_NONE;
        else if (len >= LONG_P)
            return OUT_PWRDN;
        else
            return OUT_IRQ;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [1:0] exp, input int budget, input string tag,
                              output int used);
        used = 0;
        for (int i = 0; i < budget && state_o !== exp; i++) begin
            tick(1);
            used++;
        end
        check(tag, 32'(state_o), 32'(exp));
    endtask

    task automatic power_on(input int pg_delay);
        int used;
        pwr_btn = 1'b1;
        tick(20);
        check("pwrup_state", 32'(state_o), 32'h2);
        check("pwrup_slp_s3", 32'(slp_s3), 32'h0);
        pwr_btn = 1'b0;
        tick(pg_delay);
        pwr_good = 1'b1;
        wait_state(2'b00, 10, "s0_entry", used);
        check("s0_slp_s5", 32'(slp_s5), 32'h0);
        check("s0_ready", 32'(sw_ready), 32'h1);
        tick(15);
        check("power_on_no_irq", 32'(irq_cnt), 32'(exp_irq));
    endtask

    task automatic s0_press(input int len);
        int outcome;
        int used;
        int used2;
        int rel_cyc;
        int lat;
        outcome = press_outcome(len);
        pwr_btn = 1'b1;
        if (outcome == OUT_PWRDN) begin
            wait_state(2'b10, len, "long_pwrdn", used);
            check("long_pwrdn_when", 32'(used >= LONG_P && used <= LONG_P + 12), 32'h1);
            pwr_good = 1'b0;
            wait_state(2'b11, 10, "pwrdn_to_s5", used2);
            check("s5_slp_s3", 32'(slp_s3), 32'h1);
            check("s5_slp_s5", 32'(slp_s5), 32'h1);
            check("s5_fault_clear", 32'(fault), 32'h0);
            if (len > used + used2)
                tick(len - used - used2);
            pwr_btn = 1'b0;
            tick(15);
            check("long_no_irq", 32'(irq_cnt), 32'(exp_irq));
            check("long_release_s5", 32'(state_o), 32'h3);
        end else begin
            tick(len);
            rel_cyc = cyc;
            pwr_btn = 1'b0;
            tick(15);
            if (outcome == OUT_IRQ) begin
                exp_irq++;
                lat = last_irq_cyc - rel_cyc;
                check("irq_latency", 32'(lat >= 4 && lat <= 8), 32'h1);
            end
            check("press_irq_count", 32'(irq_cnt), 32'(exp_irq));
            check("press_stays_s0", 32'(state_o), 32'h0);
        end
    endtask

    initial begin
        int used;
        int len;
        rst      = 1'b1;
        pwr_btn  = 1'b0;
        pwr_good = 1'b0;
        sw_valid = 1'b0;
        sw_state = 2'b00;
        tick(3);
        check("rst_state", 32'(state_o), 32'h3);
        check("rst_slp_s3", 32'(slp_s3), 32'h1);
        check("rst_slp_s5", 32'(slp_s5), 32'h1);
        check("rst_irq", 32'(btn_irq), 32'h0);
        check("rst_ready", 32'(sw_ready), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        rst = 1'b0;
        tick(2);

        // Glitches in S5 must not start a power-up.
        for (int k = 0; k < 3; k++) begin
            pwr_btn = 1'b1;
            tick(int'($urandom_range(1, 2)));
            pwr_btn = 1'b0;
            tick(6);
        end
        check("s5_glitch_state", 32'(state_o), 32'h3);

        power_on(int'($urandom_range(5, 10)));

        // Randomized glitches and short presses in S0.
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 0)
                len = int'($urandom_range(1, 2));
            else
                len = int'($urandom_range(8, 40));
            s0_press(len);
            tick(4);
        end

        // Forced power-down, then power-on and power-down twice more.
        s0_press(int'($urandom_range(90, 120)));
        for (int k = 0; k < 2; k++) begin
            power_on(int'($urandom_range(5, 10)));
            s0_press(int'($urandom_range(90, 120)));
        end

        // pwr_good never arrives: timeout, back to S5 with fault.
        pwr_btn = 1'b1;
        tick(20);
        check("tmo_pwrup", 32'(state_o), 32'h2);
        pwr_btn = 1'b0;
        wait_state(2'b11, TMO + 10, "tmo_to_s5", used);
        check("tmo_fault_set", 32'(fault), 32'h1);
        check("tmo_slp_s5", 32'(slp_s5), 32'h1);
        pwr_btn = 1'b1;
        tick(10);
        check("fault_cleared", 32'(fault), 32'h0);
        check("fault_clear_pwrup", 32'(state_o), 32'h2);
        pwr_btn = 1'b0;
        pwr_good = 1'b1;
        wait_state(2'b00, 15, "recover_s0", used);
        tick(15);
        check("recover_no_irq", 32'(irq_cnt), 32'(exp_irq));

        // Illegal request codes are accepted and ignored.
        sw_state = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
        sw_valid = 1'b1;
        check("illegal_ready", 32'(sw_ready), 32'h1);
        tick(1);
        sw_valid = 1'b0;
        tick(3);
        check("illegal_ignored", 32'(state_o), 32'h0);

        // S3 request.
        sw_state = 2'b01;
        sw_valid = 1'b1;
        check("s3_ready", 32'(sw_ready), 32'h1);
        tick(1);
        sw_valid = 1'b0;
        tick(2);
`ifdef PMS_ACPI_S3_EN
        check("s3_state", 32'(state_o), 32'h1);
        check("s3_slp_s3", 32'(slp_s3), 32'h1);
        check("s3_slp_s5", 32'(slp_s5), 32'h0);
        pwr_btn = 1'b1;
        wait_state(2'b00, 20, "s3_wake", used);
        pwr_btn = 1'b0;
        tick(15);
        check("s3_wake_no_irq", 32'(irq_cnt), 32'(exp_irq));
`else
        check("s3_ignored", 32'(state_o), 32'h0);
`endif

        // S5 software request.
        sw_state = 2'b11;
        sw_valid = 1'b1;
        check("s5_req_ready", 32'(sw_ready), 32'h1);
        tick(1);
        sw_valid = 1'b0;
        check("s5_req_pwrdn", 32'(state_o), 32'h2);
        pwr_good = 1'b0;
        wait_state(2'b11, 10, "s5_req_done", used);

        // Asynchronous reset in the middle of a power-up.
        pwr_btn = 1'b1;
        wait_state(2'b10, 15, "pre_rst_pwrup", used);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state_o), 32'h3);
        check("async_rst_slp", 32'({slp_s3, slp_s5}), 32'h3);
        tick(2);
        pwr_btn = 1'b0;
        rst = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
